aes128_enc_iter_ctrl: RTL and testbench
=======================================

Name: aes128_enc_iter_ctrl

Overview:
Iterative AES-128 encryption controller: one round per clock, with the round key expanded on the fly.
- Holds the 128-bit state and round-key registers, the round counter and the Rcon value.
- Applies subBytes, shiftRows, mixColumns and addRoundKey in sequence; mixColumns is skipped in the final round.
- Sits between the block-level valid/ready host interface and the existing round-function modules.

Parameters:
NUM_ROUNDS, 10, number of full rounds executed; 10 is the only FIPS-197-compliant value; smaller values (min 1) are allowed for reduced-round test only.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
i_valid  input  1  plaintext/key offered
o_ready  output  1  block can accept; high only in IDLE
i_plaintext  input  [0:127]  plaintext; byte k = bits [8k+:8], column-major per FIPS-197
i_key  input  [0:127]  cipher key, same byte order
o_valid  output  1  ciphertext available
i_ready  input  1  downstream accepts ciphertext
o_ciphertext  output  [0:127]  ciphertext, same byte order
o_busy  output  1  high in ROUND and DONE

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low. When rst_n=0 at an edge:
  - state goes to IDLE;
  - the state, key, round and Rcon registers clear to 0;
  - o_valid=0, o_busy=0, o_ciphertext=0.
  - Reset mid-operation abandons the block with no output.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready: state_reg <= i_plaintext ^ i_key; key_reg <= i_key; round <= 1; rcon <= 8'h01; go to ROUND.
- ROUND (one edge per round):
  - next_key = key_expand(key_reg, rcon).
  - If round<NUM_ROUNDS: state_reg <= mixColumns(shiftRows(subBytes(state_reg))) ^ next_key.
  - If round==NUM_ROUNDS: mixColumns is omitted.
  - Each edge: key_reg <= next_key; rcon <= xtime(rcon); round <= round+1.
  - After the round==NUM_ROUNDS edge, go to DONE.
- DONE:
  - o_valid=1; o_ciphertext=state_reg, held stable until the handshake.
  - On i_ready: go to IDLE; o_valid drops on the next cycle.
- Latency: accept at edge E0, o_valid high after edge E(NUM_ROUNDS), i.e. 10 cycles for AES-128. Throughput is one block per NUM_ROUNDS+2 cycles minimum.
- Inputs i_plaintext and i_key are sampled only at the accept edge; changes at other times are ignored.
- i_valid while busy: ignored (o_ready=0); no queuing.
- i_ready before o_valid: ignored.
- i_ready already high on DONE entry: 1-cycle o_valid pulse.
- Round counter is ceil(log2(NUM_ROUNDS+1)) bits and never wraps within a block.
- Rcon arithmetic is GF(2^8) xtime with polynomial 0x11B (0x80 -> 0x1B). The sequence for rounds 1..10 is 01,02,04,08,10,20,40,80,1B,36.
- o_ciphertext is registered; all outputs are glitch-free functions of the state register.

Optional Feature:
Macro AES_ZEROIZE_ON_DONE_EN.
- Defined: on the DONE->IDLE handshake edge, state_reg, key_reg and rcon clear to 0, so o_ciphertext reads 0 in IDLE and no key material persists.
- Undefined: registers keep their last values in IDLE, and o_ciphertext keeps showing the last result.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - NB=4, NK=4, block width 128;
  - the S-box constant array;
  - the Rcon initial value 8'h01 and reduction constant 8'h1B;
  - FSM state enum (IDLE, ROUND, DONE);
  - the xtime function.
- One sub-module: aes_key_step, combinational; takes key_reg and rcon, returns the next round key (RotWord, SubWord, Rcon XOR, word chaining).
- Existing round-function modules are instantiated, not re-implemented.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, o_valid high exactly 10 cycles after the accept edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; check the round-1 state register equals a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49.
- Backpressure: hold i_ready=0 for 20 cycles in DONE -> o_valid and o_ciphertext remain stable; o_ready=0; a new i_valid is ignored; i_ready=1 -> IDLE next cycle.
- Reset mid-operation: drive rst_n=0 for one edge at round 5 -> IDLE; o_valid=0; o_ciphertext=0. Then App. C.1 restarts and produces the correct ciphertext.
- Back-to-back: i_ready and i_valid tied high with two different blocks -> both ciphertexts are correct, spaced 12 cycles apart, and inputs changing during ROUND have no effect.
- AES_ZEROIZE_ON_DONE_EN defined -> o_ciphertext=0 one cycle after handshake; undefined -> o_ciphertext holds 69c4e0d8....

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative AES-128 encryption controller.
// Holds the block geometry (NB, NK, BLOCK_W), the forward S-box, the Rcon
// constants, the controller FSM state type and the GF(2^8) xtime helper.
// Byte k of a 128-bit block lives at bits [8k +: 8] of a [0:127] vector,
// i.e. row = k % 4, column = k / 4 (column-major).
package aes_pkg;

    localparam int NB      = 4;    // columns in the state
    localparam int NK      = 4;    // 32-bit words in an AES-128 key
    localparam int BLOCK_W = 128;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;  // x^8 reduction by 0x11B

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8); 0x80 maps to 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes128_enc_iter_ctrl_if.sv
// Host-side block interface of the AES-128 controller.
// master : host (offers plaintext/key, accepts ciphertext)
// slave  : controller
// i_valid/o_ready      plaintext+key handshake (o_ready high only in IDLE)
// i_plaintext, i_key   128-bit blocks, byte k at bits [8k +: 8]
// o_valid/i_ready      ciphertext handshake
// o_ciphertext         registered result, same byte order
// o_busy               high while a block is in flight (ROUND or DONE)
interface aes128_enc_iter_ctrl_if;
    import aes_pkg::*;

    logic               i_valid;
    logic               o_ready;
    logic [0:BLOCK_W-1] i_plaintext;
    logic [0:BLOCK_W-1] i_key;
    logic               o_valid;
    logic               i_ready;
    logic [0:BLOCK_W-1] o_ciphertext;
    logic               o_busy;

    modport master (
        output i_valid, i_plaintext, i_key, i_ready,
        input  o_ready, o_valid, o_ciphertext, o_busy
    );

    modport slave (
        input  i_valid, i_plaintext, i_key, i_ready,
        output o_ready, o_valid, o_ciphertext, o_busy
    );
endinterface

// File: rtl/aes_key_step.sv
// On-the-fly AES-128 key expansion step (combinational).
// key      : current round key (4 words, word i = bytes 4i..4i+3)
// rcon     : round constant for the key being produced
// next_key : following round key
// temp = SubWord(RotWord(w3)) ^ {rcon,00,00,00}; w'0 = w0 ^ temp;
// w'i = wi ^ w'(i-1).
module aes_key_step
    import aes_pkg::*;
(
    input  logic [0:BLOCK_W-1] key,
    input  logic [7:0]         rcon,
    output logic [0:BLOCK_W-1] next_key
);
    logic [0:31] word_in  [NK];
    logic [0:31] word_out [NK];
    logic [0:31] rot_word;
    logic [0:31] temp_word;

    for (genvar gi = 0; gi < NK; gi++) begin : g_split
        assign word_in[gi] = key[32*gi +: 32];
    end

    assign rot_word = {word_in[NK-1][8:31], word_in[NK-1][0:7]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        if (gi == 0) begin : g_rcon
            assign temp_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]) ^ rcon;
        end else begin : g_plain
            assign temp_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
        end
    end

    assign word_out[0] = word_in[0] ^ temp_word;
    for (genvar gi = 1; gi < NK; gi++) begin : g_chain
        assign word_out[gi] = word_in[gi] ^ word_out[gi-1];
    end

    for (genvar gi = 0; gi < NK; gi++) begin : g_join
        assign next_key[32*gi +: 32] = word_out[gi];
    end
endmodule

// File: rtl/aes_mix_columns.sv
// Round function: MixColumns. Each column is multiplied by the circulant
// matrix {02,03,01,01}; out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3).
// din  : 128-bit state in
// dout : 128-bit state out
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [0:BLOCK_W-1] din,
    output logic [0:BLOCK_W-1] dout
);
    for (genvar gi = 0; gi < NB; gi++) begin : g_col
        for (genvar gj = 0; gj < 4; gj++) begin : g_row
            localparam int I0 = 4 * gi + gj;
            localparam int I1 = 4 * gi + (gj + 1) % 4;
            localparam int I2 = 4 * gi + (gj + 2) % 4;
            localparam int I3 = 4 * gi + (gj + 3) % 4;
            assign dout[8*I0 +: 8] = xtime(din[8*I0 +: 8])
                                   ^ xtime(din[8*I1 +: 8]) ^ din[8*I1 +: 8]
                                   ^ din[8*I2 +: 8]
                                   ^ din[8*I3 +: 8];
        end
    end
endmodule

// File: rtl/aes_shift_rows.sv
// Round function: ShiftRows. Row r is rotated left by r columns.
// din  : 128-bit state in
// dout : 128-bit state out
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic [0:BLOCK_W-1] din,
    output logic [0:BLOCK_W-1] dout
);
    for (genvar gi = 0; gi < 4 * NB; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL + ROW) % NB);
        assign dout[8*gi +: 8] = din[8*SRC +: 8];
    end
endmodule

// File: rtl/aes_sub_bytes.sv
// Round function: SubBytes. Applies the forward S-box to every state byte.
// din  : 128-bit state in
// dout : 128-bit state out
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [0:BLOCK_W-1] din,
    output logic [0:BLOCK_W-1] dout
);
    for (genvar gi = 0; gi < 4 * NB; gi++) begin : g_byte
        assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
    end
endmodule

// File: rtl/aes128_enc_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock with the
// round key expanded on the fly.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    aes128_enc_iter_ctrl_if.slave (plaintext/key in, ciphertext out)
// Parameter NUM_ROUNDS (default 10, FIPS-197); values 1..9 give reduced-round
// variants for test only.
// Optional build macro AES_ZEROIZE_ON_DONE_EN: when defined, the state, key
// and Rcon registers are cleared on the DONE->IDLE handshake so no key
// material or result lingers in IDLE. Handshake timing is unchanged.
module aes128_enc_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes128_enc_iter_ctrl_if.slave bus
);
    localparam int                ROUND_W    = $clog2(NUM_ROUNDS + 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(1);

    fsm_state_t         fsm_reg,   fsm_next;
    logic [0:BLOCK_W-1] state_reg, state_next;
    logic [0:BLOCK_W-1] key_reg,   key_next;
    logic [ROUND_W-1:0] round_reg, round_next;
    logic [7:0]         rcon_reg,  rcon_next;

    logic [0:BLOCK_W-1] sb_out;
    logic [0:BLOCK_W-1] sr_out;
    logic [0:BLOCK_W-1] mc_out;
    logic [0:BLOCK_W-1] next_key;
    logic [0:BLOCK_W-1] round_out;
    logic               last_round;

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    aes_sub_bytes u_sub_bytes (
        .din  (state_reg),
        .dout (sb_out)
    );

    aes_shift_rows u_shift_rows (
        .din  (sb_out),
        .dout (sr_out)
    );

    aes_mix_columns u_mix_columns (
        .din  (sr_out),
        .dout (mc_out)
    );

    aes_key_step u_key_step (
        .key      (key_reg),
        .rcon     (rcon_reg),
        .next_key (next_key)
    );

    assign last_round = (round_reg == LAST_ROUND);
    // The final round skips MixColumns.
    assign round_out  = (last_round ? sr_out : mc_out) ^ next_key;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        key_next   = key_reg;
        round_next = round_reg;
        rcon_next  = rcon_reg;

        case (fsm_reg)
            IDLE: begin
                if (bus.i_valid) begin
                    state_next = bus.i_plaintext ^ bus.i_key;
                    key_next   = bus.i_key;
                    round_next = FIRST_ROUND;
                    rcon_next  = RCON_INIT;
                    fsm_next   = ROUND;
                end
            end

            ROUND: begin
                state_next = round_out;
                key_next   = next_key;
                rcon_next  = xtime(rcon_reg);
                // The counter holds at NUM_ROUNDS on the last edge so a
                // ceil(log2(NUM_ROUNDS+1))-bit register can never wrap.
                if (last_round) begin
                    fsm_next = DONE;
                end else begin
                    round_next = round_reg + 1'b1;
                end
            end

            DONE: begin
                if (bus.i_ready) begin
                    fsm_next = IDLE;
`ifdef AES_ZEROIZE_ON_DONE_EN
                    state_next = '0;
                    key_next   = '0;
                    rcon_next  = '0;
`endif
                end
            end

            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            round_reg <= '0;
            rcon_reg  <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            key_reg   <= key_next;
            round_reg <= round_next;
            rcon_reg  <= rcon_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registers
    // ------------------------------------------------------------------
    assign bus.o_ready      = (fsm_reg == IDLE);
    assign bus.o_valid      = (fsm_reg == DONE);
    assign bus.o_busy       = (fsm_reg != IDLE);
    assign bus.o_ciphertext = state_reg;

endmodule

// File: tb/tb_aes128_enc_iter_ctrl.sv
// Directed testbench for aes128_enc_iter_ctrl using FIPS-197 vectors.
// Honours AES_ZEROIZE_ON_DONE_EN for the post-handshake ciphertext value.
module tb_aes128_enc_iter_ctrl;

    localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] ARK_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] R1_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;
`ifdef AES_ZEROIZE_ON_DONE_EN
    localparam logic [0:127] IDLE_CT_C1 = 128'h0;
`else
    localparam logic [0:127] IDLE_CT_C1 = CT_C1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aes128_enc_iter_ctrl_if bus ();

    aes128_enc_iter_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Offer one block; returns at the negedge after the accept edge.
    task automatic start_block(input logic [0:127] pt, input logic [0:127] key);
        bus.i_valid     = 1'b1;
        bus.i_plaintext = pt;
        bus.i_key       = key;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_ready     = 1'b0;
        bus.i_plaintext = '0;
        bus.i_key       = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got ready/valid/busy %b required 100",
                     {bus.o_ready, bus.o_valid, bus.o_busy});
        end
        checks++;
        if (bus.o_ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL reset_ct: got %h required 0", bus.o_ciphertext);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", bus.o_ready);
        end
        $display("reset: checks so far %0d", checks);
    endtask

    task automatic test_fips_c1();
        int cycles = 0;
        bit seen = 0;
        start_block(PT_C1, KEY_C1);
        checks++;
        if ({bus.o_ready, bus.o_busy} !== 2'b01) begin
            errors++;
            $display("FAIL c1_busy: got ready/busy %b required 01", {bus.o_ready, bus.o_busy});
        end
        repeat (40) begin
            if (!seen) begin
                @(negedge clk);
                cycles++;
                if (bus.o_valid === 1'b1) seen = 1;
            end
        end
        checks++;
        if (cycles != 10) begin
            errors++;
            $display("FAIL c1_latency: got %0d cycles required 10", cycles);
        end
        checks++;
        if (bus.o_ciphertext !== CT_C1) begin
            errors++;
            $display("FAIL c1_ct: got %h required %h", bus.o_ciphertext, CT_C1);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        checks++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL c1_handshake: got valid/ready %b required 01", {bus.o_valid, bus.o_ready});
        end
        $display("fips_c1: ct %h latency %0d", bus.o_ciphertext, cycles);
    endtask

    task automatic test_fips_b();
        bit seen = 0;
        start_block(PT_B, KEY_B);
        checks++;
        if (bus.o_ciphertext !== ARK_B) begin
            errors++;
            $display("FAIL b_round0: got %h required %h", bus.o_ciphertext, ARK_B);
        end
        @(negedge clk);
        checks++;
        if (bus.o_ciphertext !== R1_B) begin
            errors++;
            $display("FAIL b_round1: got %h required %h", bus.o_ciphertext, R1_B);
        end
        repeat (40) begin
            if (!seen) begin
                @(negedge clk);
                if (bus.o_valid === 1'b1) seen = 1;
            end
        end
        checks++;
        if (!seen || bus.o_ciphertext !== CT_B) begin
            errors++;
            $display("FAIL b_ct: got valid %0d ct %h required valid 1 ct %h",
                     seen, bus.o_ciphertext, CT_B);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        $display("fips_b: ct %h", CT_B);
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        start_block(PT_C1, KEY_C1);
        repeat (40) begin
            if (!seen) begin
                @(negedge clk);
                if (bus.o_valid === 1'b1) seen = 1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout: got no o_valid required o_valid within 40 cycles");
        end
        // A new offer while DONE must be ignored.
        bus.i_valid     = 1'b1;
        bus.i_plaintext = PT_B;
        bus.i_key       = KEY_B;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.o_valid, bus.o_ready, bus.o_busy} !== 3'b101 || bus.o_ciphertext !== CT_C1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid/ready/busy %b ct %h required 101 ct %h",
                         i, {bus.o_valid, bus.o_ready, bus.o_busy}, bus.o_ciphertext, CT_C1);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: got valid/ready/busy %b required 010",
                     {bus.o_valid, bus.o_ready, bus.o_busy});
        end
        checks++;
        if (bus.o_ciphertext !== IDLE_CT_C1) begin
            errors++;
            $display("FAIL idle_ct: got %h required %h", bus.o_ciphertext, IDLE_CT_C1);
        end
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_ciphertext !== IDLE_CT_C1) begin
            errors++;
            $display("FAIL idle_hold: got busy %b ct %h required busy 0 ct %h",
                     bus.o_busy, bus.o_ciphertext, IDLE_CT_C1);
        end
        $display("backpressure: idle ct %h", bus.o_ciphertext);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        start_block(PT_C1, KEY_C1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset_flags: got valid/busy/ready %b required 001",
                     {bus.o_valid, bus.o_busy, bus.o_ready});
        end
        checks++;
        if (bus.o_ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_ct: got %h required 0", bus.o_ciphertext);
        end
        @(negedge clk);
        start_block(PT_C1, KEY_C1);
        repeat (40) begin
            if (!seen) begin
                @(negedge clk);
                if (bus.o_valid === 1'b1) seen = 1;
            end
        end
        checks++;
        if (!seen || bus.o_ciphertext !== CT_C1) begin
            errors++;
            $display("FAIL mid_reset_restart: got valid %0d ct %h required valid 1 ct %h",
                     seen, bus.o_ciphertext, CT_C1);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        $display("reset_mid: restart ct %h", CT_C1);
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int t_a = 0;
        int t_b = 0;
        int nvalid = 0;
        bit garbage = 0;
        logic [0:127] ct_a = '0;
        logic [0:127] ct_b = '0;
        bus.i_ready     = 1'b1;
        bus.i_valid     = 1'b1;
        bus.i_plaintext = PT_C1;
        bus.i_key       = KEY_C1;
        @(negedge clk);
        // Block A accepted; the next offer changes while A is in ROUND.
        bus.i_plaintext = PT_B;
        bus.i_key       = KEY_B;
        while (nvalid < 2 && t < 60) begin
            @(negedge clk);
            t++;
            if (bus.o_valid === 1'b1) begin
                if (nvalid == 0) begin
                    t_a  = t;
                    ct_a = bus.o_ciphertext;
                end else begin
                    t_b  = t;
                    ct_b = bus.o_ciphertext;
                    bus.i_valid = 1'b0;
                end
                nvalid++;
            end else if (nvalid == 1 && !garbage && bus.o_busy === 1'b1) begin
                bus.i_plaintext = ~PT_B;
                bus.i_key       = ~KEY_B;
                garbage = 1;
            end
        end
        checks++;
        if (nvalid != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 2", nvalid);
        end
        checks++;
        if (t_a != 10) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d required 10", t_a);
        end
        checks++;
        if (t_b - t_a != 12) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required 12", t_b - t_a);
        end
        checks++;
        if (ct_a !== CT_C1) begin
            errors++;
            $display("FAIL b2b_ct_a: got %h required %h", ct_a, CT_C1);
        end
        checks++;
        if (ct_b !== CT_B) begin
            errors++;
            $display("FAIL b2b_ct_b: got %h required %h", ct_b, CT_B);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_pulse: got valid/busy %b required 00", {bus.o_valid, bus.o_busy});
        end
        bus.i_ready = 1'b0;
        $display("back_to_back: t_a %0d t_b %0d", t_a, t_b);
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
